// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared video-stream types and frame geometry for the kernel column
// interface between kernel_line_buffer (producer) and vertex_detection
// (consumer).
//   H_ACTIVE / V_ACTIVE  : default active frame geometry
//   pixel_t              : 16-bit pixel
//   hcount_t / vcount_t  : raster coordinates
//   kernel_column_t      : column of KERNEL_SIZE_DEFAULT pixels, index 0 is
//                          the oldest line. Blocks built with another kernel
//                          size declare pixel_t [KERNEL_SIZE-1:0], which has
//                          the same layout.
// ---------------------------------------------------------------------------
package video_pkg;

    localparam int H_ACTIVE            = 1280;
    localparam int V_ACTIVE            = 720;
    localparam int KERNEL_SIZE_DEFAULT = 11;

    typedef logic [15:0] pixel_t;
    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    typedef pixel_t [KERNEL_SIZE_DEFAULT-1:0] kernel_column_t;

endpackage

// File: rtl/row_ram.sv
// ---------------------------------------------------------------------------
// row_ram
// One stored video line: simple dual-port RAM, one write port and one read
// port, registered read (1 cycle). Contents are never reset.
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address (pixel column)
//   wr_data  : pixel to store
//   re       : read enable; rd_data holds when low
//   rd_addr  : read address (pixel column)
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module row_ram
    import video_pkg::*;
#(
    parameter int DEPTH  = H_ACTIVE,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_data
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/kernel_line_buffer.sv
// ---------------------------------------------------------------------------
// kernel_line_buffer
// Stores the most recent KERNEL_SIZE complete lines of a raster pixel stream
// in KERNEL_SIZE+1 rotating row RAMs and, for every in-range input pixel,
// emits the KERNEL_SIZE-tall column at that hcount (index 0 = oldest line).
// The output is tagged with the coordinates of the column's centre line.
//   clk_in          : clock
//   rst_in          : asynchronous active-high reset
//   pixel_data_in   : input pixel
//   hcount_in       : input pixel column
//   vcount_in       : input pixel line
//   data_valid_in   : qualifies the three inputs above
//   data_out        : kernel column, index 0 = oldest line
//   hcount_out      : column of data_out
//   vcount_out      : centre-line coordinate of data_out (wraps by V_ACTIVE)
//   data_valid_out  : data_out is a fully primed column (2 cycles latency)
//   primed_out      : KERNEL_SIZE complete lines stored since reset
// ---------------------------------------------------------------------------
module kernel_line_buffer
    import video_pkg::*;
#(
    parameter int KERNEL_SIZE = 11,
    parameter int H_ACTIVE    = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = video_pkg::V_ACTIVE
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  pixel_t                     pixel_data_in,
    input  hcount_t                    hcount_in,
    input  vcount_t                    vcount_in,
    input  logic                       data_valid_in,
    output pixel_t [KERNEL_SIZE-1:0]   data_out,
    output hcount_t                    hcount_out,
    output vcount_t                    vcount_out,
    output logic                       data_valid_out,
    output logic                       primed_out
);

    localparam int NUM_ROWS = KERNEL_SIZE + 1;
    localparam int IDX_W    = $clog2(NUM_ROWS);
    localparam int ADDR_W   = $clog2(H_ACTIVE);

    localparam logic signed [10:0] CENTRE_OFS = 11'((KERNEL_SIZE + 1) / 2);
    localparam logic signed [10:0] V_WRAP     = 11'(V_ACTIVE);

    typedef logic [IDX_W-1:0] idx_t;

    if (KERNEL_SIZE < 3 || (KERNEL_SIZE % 2) == 0) begin : g_bad_kernel
        $error("KERNEL_SIZE must be odd and at least 3");
    end

    // Row RAM holding column entry k, given the RAM currently being written.
    // base <= KERNEL_SIZE and k <= KERNEL_SIZE-1, so a single conditional
    // subtraction implements the modulo.
    function automatic idx_t col_sel(input idx_t base, input int k);
        logic [IDX_W:0] s;
        s = {1'b0, base} + (IDX_W+1)'(k + 1);
        if (s >= (IDX_W+1)'(NUM_ROWS)) begin
            s = s - (IDX_W+1)'(NUM_ROWS);
        end
        return s[IDX_W-1:0];
    endfunction

    // Centre line of the column = newest stored line minus half the kernel,
    // which can fall into the previous frame.
    function automatic vcount_t centre_line(input vcount_t v);
        logic signed [10:0] t;
        t = $signed({1'b0, v}) - CENTRE_OFS;
        if (t < 0) begin
            t = t + V_WRAP;
        end
        return t[9:0];
    endfunction

    // Reset: asserted asynchronously, released synchronously.
    logic [1:0] rst_sync;
    logic       rst;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst = rst_sync[1];

    // ---- stage p0: request, RAM write/read issue, rotation control ----
    logic  req_p0;
    logic  line_end_p0;
    idx_t  wr_idx;
    idx_t  lines_filled;

    assign req_p0      = data_valid_in && (hcount_in < hcount_t'(H_ACTIVE));
    assign line_end_p0 = req_p0 && (hcount_in == hcount_t'(H_ACTIVE - 1));
    assign primed_out  = (lines_filled == idx_t'(KERNEL_SIZE));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_idx       <= '0;
            lines_filled <= '0;
        end else if (line_end_p0) begin
            wr_idx <= (wr_idx == idx_t'(KERNEL_SIZE)) ? '0 : wr_idx + 1'b1;
            if (!primed_out) begin
                lines_filled <= lines_filled + 1'b1;
            end
        end
    end

    pixel_t rd_data [NUM_ROWS];

    for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
        row_ram #(
            .DEPTH (H_ACTIVE),
            .ADDR_W(ADDR_W)
        ) u_row (
            .clk    (clk_in),
            .we     (req_p0 && (wr_idx == idx_t'(g))),
            .wr_addr(hcount_in[ADDR_W-1:0]),
            .wr_data(pixel_data_in),
            .re     (req_p0 && (wr_idx != idx_t'(g))),
            .rd_addr(hcount_in[ADDR_W-1:0]),
            .rd_data(rd_data[g])
        );
    end

    // ---- stage p1: RAM read data available, request tags alongside ----
    logic    vld_p1;
    hcount_t hcount_p1;
    vcount_t vcount_p1;
    idx_t    widx_p1;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= req_p0 && primed_out;
        end
    end

    always_ff @(posedge clk_in) begin
        if (req_p0) begin
            hcount_p1 <= hcount_in;
            vcount_p1 <= vcount_in;
            widx_p1   <= wr_idx;
        end
    end

    // ---- stage p2: column reorder into output register ----
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= vld_p1;
            if (vld_p1) begin
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    data_out[k] <= rd_data[col_sel(widx_p1, k)];
                end
                hcount_out <= hcount_p1;
                vcount_out <= centre_line(vcount_p1);
            end
        end
    end

endmodule

// File: tb/tb_kernel_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_kernel_line_buffer
// Directed bench for kernel_line_buffer at KERNEL_SIZE=3, H_ACTIVE=8,
// V_ACTIVE=6 with pixel = (v<<8)|h. Every step compares the outputs against
// a small line-history model, plus literal hand-computed columns at the
// priming, rotation, frame-wrap, bubble, out-of-range and reset points.
// ---------------------------------------------------------------------------
module tb_kernel_line_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] pixel_data_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic [47:0] data_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;
    logic        primed_out;

    kernel_line_buffer #(
        .KERNEL_SIZE(3),
        .H_ACTIVE   (8),
        .V_ACTIVE   (6)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pixel_data_in (pixel_data_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .data_valid_in (data_valid_in),
        .data_out      (data_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .data_valid_out(data_valid_out),
        .primed_out    (primed_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state: frame-local v of each completed line since reset,
    // the previous request's expectation and the held output values.
    int          lines_v [$];
    int          filled;
    logic        p_vld_exp;
    logic [47:0] p_data;
    int          p_h, p_v;
    logic [47:0] last_data;
    int          last_h, last_v;

    task automatic model_reset();
        lines_v.delete();
        filled    = 0;
        p_vld_exp = 1'b0;
        p_data    = '0;
        p_h       = 0;
        p_v       = 0;
        last_data = '0;
        last_h    = 0;
        last_v    = 0;
    endtask

    // One clock: present a request, then check the outputs produced by the
    // previous request (two cycles after it was presented).
    task automatic step(input logic vld, input int v, input int h);
        logic inr;
        int   n;
        int   lv;
        data_valid_in = vld;
        pixel_data_in = 16'((v << 8) | h);
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        @(posedge clk_in);
        #1;
        if (p_vld_exp) begin
            last_data = p_data;
            last_h    = p_h;
            last_v    = (p_v - 2 < 0) ? p_v - 2 + 6 : p_v - 2;
        end
        check("valid", data_valid_out, p_vld_exp);
        check("data", data_out, last_data);
        check("hcount", hcount_out, last_h);
        check("vcount", vcount_out, last_v);
        inr       = vld && (h < 8);
        p_vld_exp = inr && (filled == 3);
        p_h       = h;
        p_v       = v;
        if (p_vld_exp) begin
            n = lines_v.size();
            for (int k = 0; k < 3; k++) begin
                lv = lines_v[n - 3 + k];
                p_data[k*16 +: 16] = 16'((lv << 8) | h);
            end
        end
        if (inr && h == 7) begin
            lines_v.push_back(v);
            if (filled < 3) filled++;
        end
        check("primed", primed_out, filled == 3);
    endtask

    initial begin
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        pixel_data_in = '0;
        hcount_in     = '0;
        vcount_in     = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_valid", data_valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_primed", primed_out, 0);
        rst_in = 1'b0;
        repeat (3) step(1'b0, 0, 0);

        // Frame 0: priming, then the rotation wraps past the last RAM
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 8; h++) begin
                step(1'b1, v, h);
                if (v == 3 && h == 1) begin
                    check("prime_vld", data_valid_out, 1);
                    check("prime_col", data_out, 48'h0200_0100_0000);
                    check("prime_h", hcount_out, 0);
                    check("prime_v", vcount_out, 1);
                end
                if (v == 5 && h == 6) begin
                    check("rot_col", data_out, 48'h0405_0305_0205);
                    check("rot_v", vcount_out, 3);
                end
            end
        end

        // Frame 1, line 0: top rows come from the previous frame
        for (int h = 0; h < 8; h++) begin
            step(1'b1, 0, h);
            if (h == 3) begin
                check("fwrap_col", data_out, 48'h0502_0402_0302);
                check("fwrap_v", vcount_out, 4);
            end
        end

        // Frame 1, line 1: a bubble after every pixel
        for (int h = 0; h < 8; h++) begin
            step(1'b1, 1, h);
            if (h == 5) begin
                check("bubble_gap_vld", data_valid_out, 0);
                check("bubble_hold", data_out, 48'h0004_0504_0404);
            end
            step(1'b0, 0, 0);
            if (h == 4) begin
                check("bubble_vld", data_valid_out, 1);
                check("bubble_col", data_out, 48'h0004_0504_0404);
                check("bubble_v", vcount_out, 5);
            end
        end

        // Frame 1, line 2: an out-of-range pixel in the middle of the line
        for (int h = 0; h < 8; h++) begin
            step(1'b1, 2, h);
            if (h == 3) step(1'b1, 2, 9);
            if (h == 4) check("oor_vld", data_valid_out, 0);
        end

        // Frame 1, line 3: columns of line 2 must be intact
        for (int h = 0; h < 8; h++) begin
            step(1'b1, 3, h);
            if (h == 4) begin
                check("oor_col", data_out, 48'h0203_0103_0003);
                check("oor_v", vcount_out, 1);
            end
        end

        // Frame 1, line 4: reset in the middle of the line
        for (int h = 0; h < 4; h++) step(1'b1, 4, h);
        rst_in = 1'b1;
        #1;
        check("mid_rst_valid", data_valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_h", hcount_out, 0);
        check("mid_rst_v", vcount_out, 0);
        check("mid_rst_primed", primed_out, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
        repeat (3) step(1'b0, 0, 0);

        // Re-priming needs three full lines again
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 8; h++) begin
                step(1'b1, v, h);
                if (v == 3 && h == 1) begin
                    check("reprime_vld", data_valid_out, 1);
                    check("reprime_col", data_out, 48'h0200_0100_0000);
                end
            end
        end
        repeat (3) step(1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
